// File: rtl/ldo_handover_seq_if.sv
// Signal bundle between the register file / power supervisor (master) and the
// DLDO/ALDO handover sequencer (slave).
interface ldo_handover_seq_if #(
  parameter int NUM_DLDO  = 2,
  parameter int DLDO_SEGS = 64,
  parameter int CNT_W     = 7,
  parameter int ALDO_SEGS = 15,
  parameter int ALDO_W    = 4,
  parameter int TIMER_W   = 16
);
  logic                          trig;
  logic                          cfg_en;
  logic                          cfg_reverse_en;
  logic                          cfg_aldo_ramp;
  logic [TIMER_W-1:0]            cfg_timer;
  logic [2*NUM_DLDO-1:0]         cfg_step_rate;
  logic [CNT_W*NUM_DLDO-1:0]     cfg_dldo_init;
  logic [ALDO_W-1:0]             cfg_aldo_target;
  logic [DLDO_SEGS*NUM_DLDO-1:0] dldo_en_n;
  logic [ALDO_SEGS-1:0]          aldo_en;
  logic                          status;
  logic                          done_pulse;
  logic [1:0]                    state_o;

  modport master (
    output trig, cfg_en, cfg_reverse_en, cfg_aldo_ramp, cfg_timer,
           cfg_step_rate, cfg_dldo_init, cfg_aldo_target,
    input  dldo_en_n, aldo_en, status, done_pulse, state_o
  );

  modport slave (
    input  trig, cfg_en, cfg_reverse_en, cfg_aldo_ramp, cfg_timer,
           cfg_step_rate, cfg_dldo_init, cfg_aldo_target,
    output dldo_en_n, aldo_en, status, done_pulse, state_o
  );
endinterface

// File: rtl/ldo_handover_seq.sv
// Multi-channel handover sequencer: ramps DLDO thermometer banks down and the ALDO
// bias bank up on trig, and optionally ramps back to the initial state on release.
module ldo_handover_seq #(
  parameter int NUM_DLDO  = 2,
  parameter int DLDO_SEGS = 64,
  parameter int CNT_W     = 7,
  parameter int ALDO_SEGS = 15,
  parameter int ALDO_W    = 4,
  parameter int TIMER_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  ldo_handover_seq_if.slave bus
);

  localparam int CW = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAMP_DN = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RAMP_UP = 2'd3
  } state_e;

  typedef logic [NUM_DLDO-1:0][CNT_W-1:0] cnt_vec_t;
  typedef logic [NUM_DLDO-1:0][CW-1:0]    step_vec_t;

  function automatic logic [CW-1:0] step_of(input logic [1:0] code);
    return CW'(1) << code;
  endfunction

  function automatic logic [CNT_W-1:0] sat_init(input logic [CNT_W-1:0] v);
    if (v > CNT_W'(DLDO_SEGS)) begin
      return CNT_W'(DLDO_SEGS);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [ALDO_W-1:0] sat_target(input logic [ALDO_W-1:0] v);
    if (v > ALDO_W'(ALDO_SEGS)) begin
      return ALDO_W'(ALDO_SEGS);
    end else begin
      return v;
    end
  endfunction

  // Arithmetic is done one bit wider than the count so a large step never wraps.
  function automatic logic [CNT_W-1:0] ramp_dn(input logic [CNT_W-1:0] cnt,
                                               input logic [CW-1:0]    step);
    logic [CW-1:0] ext;
    ext = {1'b0, cnt};
    if (ext > step) begin
      return CNT_W'(ext - step);
    end else begin
      return '0;
    end
  endfunction

  function automatic logic [CNT_W-1:0] ramp_up(input logic [CNT_W-1:0] cnt,
                                               input logic [CW-1:0]    step,
                                               input logic [CNT_W-1:0] ceil);
    logic [CW-1:0] sum;
    sum = {1'b0, cnt} + step;
    if (sum > {1'b0, ceil}) begin
      return ceil;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  state_e                        state_q, state_d;
  cnt_vec_t                      dldo_cnt_q, dldo_cnt_d;
  logic [ALDO_W-1:0]             aldo_cnt_q, aldo_cnt_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic                          trig_prev_q, trig_prev_d;
  logic [DLDO_SEGS*NUM_DLDO-1:0] dldo_en_n_q, dldo_en_n_d;
  logic [ALDO_SEGS-1:0]          aldo_en_q, aldo_en_d;
  logic                          status_q, status_d;
  logic                          done_pulse_q, done_pulse_d;

  logic                          rise_s, fall_s;
  cnt_vec_t                      init_s, cnt_dn_s, cnt_up_s;
  step_vec_t                     step_s;
  logic [ALDO_W-1:0]             target_s, aldo_dn_s, aldo_up_s;
  logic [TIMER_W-1:0]            timer_dec_s;
  logic                          dldo_zero_s, dldo_home_s;
  logic                          dn_done_s, up_done_s;

  // Trigger edges, saturated configuration and the candidate ramp values.
  always_comb begin
    rise_s      = bus.trig & ~trig_prev_q;
    fall_s      = ~bus.trig & trig_prev_q;
    target_s    = sat_target(bus.cfg_aldo_target);
    timer_dec_s = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);
    dldo_zero_s = 1'b1;
    dldo_home_s = 1'b1;
    init_s      = '0;
    step_s      = '0;
    cnt_dn_s    = '0;
    cnt_up_s    = '0;
    for (int k = 0; k < NUM_DLDO; k++) begin
      init_s[k]   = sat_init(bus.cfg_dldo_init[k*CNT_W +: CNT_W]);
      step_s[k]   = step_of(bus.cfg_step_rate[2*k +: 2]);
      cnt_dn_s[k] = ramp_dn(dldo_cnt_q[k], step_s[k]);
      cnt_up_s[k] = ramp_up(dldo_cnt_q[k], step_s[k], init_s[k]);
      dldo_zero_s = dldo_zero_s & (dldo_cnt_q[k] == '0);
      dldo_home_s = dldo_home_s & (dldo_cnt_q[k] == init_s[k]);
    end
    if (bus.cfg_aldo_ramp) begin
      aldo_dn_s = (aldo_cnt_q >= target_s) ? target_s : aldo_cnt_q + ALDO_W'(1);
      aldo_up_s = (aldo_cnt_q == '0) ? '0 : aldo_cnt_q - ALDO_W'(1);
    end else begin
      aldo_dn_s = target_s;
      aldo_up_s = '0;
    end
    dn_done_s = (timer_q == '0) | (dldo_zero_s & (aldo_cnt_q == target_s));
    up_done_s = (timer_q == '0) | (dldo_home_s & (aldo_cnt_q == '0));
  end

  // Sequencer next state; transition edges hold the counts, ramp edges move them.
  always_comb begin
    state_d      = state_q;
    dldo_cnt_d   = dldo_cnt_q;
    aldo_cnt_d   = aldo_cnt_q;
    timer_d      = timer_q;
    done_pulse_d = 1'b0;
    trig_prev_d  = bus.trig;
    if (!bus.cfg_en) begin
      state_d = ST_IDLE;
      if (state_q == ST_IDLE) begin
        dldo_cnt_d = init_s;
        aldo_cnt_d = '0;
      end else begin
        dldo_cnt_d = dldo_cnt_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          dldo_cnt_d = init_s;
          aldo_cnt_d = '0;
          if (rise_s) begin
            timer_d = bus.cfg_timer;
            state_d = ST_RAMP_DN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP_DN: begin
          if (fall_s) begin
            state_d = bus.cfg_reverse_en ? ST_RAMP_UP : ST_IDLE;
            timer_d = bus.cfg_reverse_en ? bus.cfg_timer : timer_q;
          end else if (dn_done_s) begin
            dldo_cnt_d   = '0;
            aldo_cnt_d   = target_s;
            state_d      = ST_HOLD;
            done_pulse_d = 1'b1;
          end else begin
            dldo_cnt_d = cnt_dn_s;
            aldo_cnt_d = aldo_dn_s;
            timer_d    = timer_dec_s;
          end
        end
        ST_HOLD: begin
          if (fall_s) begin
            state_d = bus.cfg_reverse_en ? ST_RAMP_UP : ST_IDLE;
            timer_d = bus.cfg_reverse_en ? bus.cfg_timer : timer_q;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_RAMP_UP: begin
          if (rise_s) begin
            timer_d = bus.cfg_timer;
            state_d = ST_RAMP_DN;
          end else if (up_done_s) begin
            state_d      = ST_IDLE;
            done_pulse_d = 1'b1;
          end else begin
            dldo_cnt_d = cnt_up_s;
            aldo_cnt_d = aldo_up_s;
            timer_d    = timer_dec_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    status_d = (state_d == ST_IDLE) | (state_d == ST_HOLD);
  end

  // Thermometer decode of the current counts, registered one cycle behind them.
  always_comb begin
    dldo_en_n_d = '1;
    aldo_en_d   = '0;
    for (int k = 0; k < NUM_DLDO; k++) begin
      for (int i = 0; i < DLDO_SEGS; i++) begin
        dldo_en_n_d[k*DLDO_SEGS + i] = ~(dldo_cnt_q[k] > CNT_W'(i));
      end
    end
    for (int i = 0; i < ALDO_SEGS; i++) begin
      aldo_en_d[i] = (aldo_cnt_q > ALDO_W'(i));
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dldo_cnt_q   <= '0;
      aldo_cnt_q   <= '0;
      timer_q      <= '0;
      trig_prev_q  <= 1'b0;
      dldo_en_n_q  <= '1;
      aldo_en_q    <= '0;
      status_q     <= 1'b1;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dldo_cnt_q   <= dldo_cnt_d;
      aldo_cnt_q   <= aldo_cnt_d;
      timer_q      <= timer_d;
      trig_prev_q  <= trig_prev_d;
      dldo_en_n_q  <= dldo_en_n_d;
      aldo_en_q    <= aldo_en_d;
      status_q     <= status_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bus.dldo_en_n  = dldo_en_n_q;
  assign bus.aldo_en    = aldo_en_q;
  assign bus.status     = status_q;
  assign bus.done_pulse = done_pulse_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_ldo_handover_seq.sv
// Scoreboard bench for ldo_handover_seq: directed test-plan phases followed by
// randomized traffic, checked every cycle against a behavioural count model.
module tb_ldo_handover_seq;
  localparam int NUM_DLDO  = 2;
  localparam int DLDO_SEGS = 64;
  localparam int CNT_W     = 7;
  localparam int ALDO_SEGS = 15;
  localparam int ALDO_W    = 4;
  localparam int TIMER_W   = 16;

  localparam int M_IDLE = 0;
  localparam int M_DN   = 1;
  localparam int M_HOLD = 2;
  localparam int M_UP   = 3;

  typedef struct packed {
    logic [NUM_DLDO*DLDO_SEGS-1:0] dn;
    logic [ALDO_SEGS-1:0]          ae;
    logic                          st;
    logic                          dp;
    logic [1:0]                    so;
  } exp_t;

  logic clk;
  logic rst;
  ldo_handover_seq_if #(
    .NUM_DLDO(NUM_DLDO), .DLDO_SEGS(DLDO_SEGS), .CNT_W(CNT_W),
    .ALDO_SEGS(ALDO_SEGS), .ALDO_W(ALDO_W), .TIMER_W(TIMER_W)
  ) bus ();

  ldo_handover_seq #(
    .NUM_DLDO(NUM_DLDO), .DLDO_SEGS(DLDO_SEGS), .CNT_W(CNT_W),
    .ALDO_SEGS(ALDO_SEGS), .ALDO_W(ALDO_W), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Behavioural model: counts held as plain integers.
  int m_mode;
  int m_cnt [NUM_DLDO];
  int m_aldo;
  int m_timer;
  bit m_prev;

  task automatic model_step();
    exp_t e;
    int   init_k [NUM_DLDO];
    int   step_k [NUM_DLDO];
    int   tgt;
    bit   rise, fall, done, all_off, all_home;
    logic [DLDO_SEGS-1:0] ones;
    logic [ALDO_SEGS:0]   pw;
    ones = '1;
    done = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_aldo = 0; m_timer = 0; m_prev = 1'b0;
      foreach (m_cnt[k]) m_cnt[k] = 0;
      e.dn = '1;
      e.ae = '0;
    end else begin
      for (int k = 0; k < NUM_DLDO; k++) e.dn[k*DLDO_SEGS +: DLDO_SEGS] = ones << m_cnt[k];
      pw = '0;
      pw[0] = 1'b1;
      pw = pw << m_aldo;
      pw = pw - 1'b1;
      e.ae = pw[ALDO_SEGS-1:0];
      for (int k = 0; k < NUM_DLDO; k++) begin
        init_k[k] = int'(bus.cfg_dldo_init[k*CNT_W +: CNT_W]);
        if (init_k[k] > DLDO_SEGS) init_k[k] = DLDO_SEGS;
        step_k[k] = 1 << bus.cfg_step_rate[2*k +: 2];
      end
      tgt = int'(bus.cfg_aldo_target);
      if (tgt > ALDO_SEGS) tgt = ALDO_SEGS;
      rise = bus.trig && !m_prev;
      fall = !bus.trig && m_prev;
      all_off = 1'b1;
      all_home = 1'b1;
      for (int k = 0; k < NUM_DLDO; k++) begin
        if (m_cnt[k] != 0) all_off = 1'b0;
        if (m_cnt[k] != init_k[k]) all_home = 1'b0;
      end
      if (!bus.cfg_en || m_mode == M_IDLE) begin
        if (m_mode == M_IDLE) begin
          for (int k = 0; k < NUM_DLDO; k++) m_cnt[k] = init_k[k];
          m_aldo = 0;
        end
        if (bus.cfg_en && rise) begin
          m_timer = int'(bus.cfg_timer);
          m_mode  = M_DN;
        end else begin
          m_mode = M_IDLE;
        end
      end else if ((m_mode == M_DN || m_mode == M_HOLD) && fall) begin
        if (bus.cfg_reverse_en) begin
          m_mode  = M_UP;
          m_timer = int'(bus.cfg_timer);
        end else begin
          m_mode = M_IDLE;
        end
      end else if (m_mode == M_DN) begin
        if (m_timer == 0 || (all_off && m_aldo == tgt)) begin
          foreach (m_cnt[k]) m_cnt[k] = 0;
          m_aldo = tgt;
          m_mode = M_HOLD;
          done   = 1'b1;
        end else begin
          for (int k = 0; k < NUM_DLDO; k++)
            m_cnt[k] = (m_cnt[k] - step_k[k] < 0) ? 0 : m_cnt[k] - step_k[k];
          if (bus.cfg_aldo_ramp) m_aldo = (m_aldo + 1 > tgt) ? tgt : m_aldo + 1;
          else m_aldo = tgt;
          m_timer = (m_timer > 0) ? m_timer - 1 : 0;
        end
      end else if (m_mode == M_UP) begin
        if (rise) begin
          m_timer = int'(bus.cfg_timer);
          m_mode  = M_DN;
        end else if (m_timer == 0 || (all_home && m_aldo == 0)) begin
          m_mode = M_IDLE;
          done   = 1'b1;
        end else begin
          for (int k = 0; k < NUM_DLDO; k++)
            m_cnt[k] = (m_cnt[k] + step_k[k] > init_k[k]) ? init_k[k] : m_cnt[k] + step_k[k];
          m_aldo  = (bus.cfg_aldo_ramp && m_aldo > 0) ? m_aldo - 1 : 0;
          m_timer = (m_timer > 0) ? m_timer - 1 : 0;
        end
      end
      m_prev = bus.trig;
    end
    e.st = (m_mode == M_IDLE) || (m_mode == M_HOLD);
    e.dp = done;
    e.so = 2'(m_mode);
    exp_q.push_back(e);
  endtask

  // One clock: the model consumes the inputs sampled at this edge, then inputs may change.
  task automatic cyc(input int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_step();
      cyc_n++;
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_n, act, req);
    end
  endtask

  // Monitor: compares the DUT outputs with the oldest expected entry each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dldo_en_n",  128'(bus.dldo_en_n),  128'(e.dn));
        chk("aldo_en",    128'(bus.aldo_en),    128'(e.ae));
        chk("status",     128'(bus.status),     128'(e.st));
        chk("done_pulse", 128'(bus.done_pulse), 128'(e.dp));
        chk("state_o",    128'(bus.state_o),    128'(e.so));
      end
    end
  end

  task automatic set_init(input int a, input int b);
    bus.cfg_dldo_init = {CNT_W'(b), CNT_W'(a)};
  endtask

  task automatic randomize_cfg();
    bus.cfg_timer       = TIMER_W'($urandom_range(0, 40));
    for (int k = 0; k < NUM_DLDO; k++)
      bus.cfg_dldo_init[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 127));
    bus.cfg_step_rate   = (2*NUM_DLDO)'($urandom);
    bus.cfg_aldo_target = ALDO_W'($urandom_range(0, 15));
    bus.cfg_aldo_ramp   = 1'($urandom);
    bus.cfg_reverse_en  = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    bus.trig = 1'b0; bus.cfg_en = 1'b0; bus.cfg_reverse_en = 1'b0;
    bus.cfg_aldo_ramp = 1'b0; bus.cfg_timer = '0; bus.cfg_step_rate = '0;
    bus.cfg_dldo_init = '0; bus.cfg_aldo_target = '0;
    cyc(3);
    // Idle load of the initial counts.
    rst = 1'b0; bus.cfg_en = 1'b1; set_init(10, 20);
    bus.cfg_step_rate = 4'b0100; bus.cfg_timer = 16'd100; bus.cfg_aldo_target = 4'd5;
    cyc(4);
    // Ramp down with direct ALDO set, early completion, then abort release.
    bus.trig = 1'b1; cyc(15);
    bus.trig = 1'b0; cyc(3);
    // Ramped ALDO to full scale, reverse handover back to idle.
    bus.cfg_aldo_target = 4'd15; bus.cfg_aldo_ramp = 1'b1; bus.cfg_reverse_en = 1'b1;
    bus.trig = 1'b1; cyc(20);
    bus.trig = 1'b0; cyc(22);
    // Release mid-ramp without reverse.
    bus.cfg_reverse_en = 1'b0; bus.trig = 1'b1; cyc(4);
    bus.trig = 1'b0; cyc(4);
    // Timeout forcing completion from full banks.
    bus.cfg_timer = 16'd3; set_init(64, 64); bus.cfg_step_rate = 4'b0000;
    bus.trig = 1'b1; cyc(8);
    bus.trig = 1'b0; cyc(3);
    // Saturated init, enable drop during ramp-up, reset mid-ramp.
    bus.cfg_timer = 16'd100; set_init(100, 100); bus.cfg_reverse_en = 1'b1;
    bus.cfg_step_rate = 4'b1011;
    bus.trig = 1'b1; cyc(12);
    bus.trig = 1'b0; cyc(3);
    bus.cfg_en = 1'b0; cyc(2);
    bus.cfg_en = 1'b1; cyc(2);
    bus.trig = 1'b1; cyc(5);
    rst = 1'b1; cyc(1);
    rst = 1'b0; cyc(3);
    bus.trig = 1'b0; cyc(2);
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) randomize_cfg();
      if ($urandom_range(0, 11) == 0) bus.trig = ~bus.trig;
      bus.cfg_en = ($urandom_range(0, 149) != 0);
      rst = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
